// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller for the 5-stage pipeline.
// Arbitrates PC updates: halt > taken-branch redirect > load-use stall > sequential.
// Holds a multi-cycle flush after each accepted redirect and a HALT state left by resume.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             stall_req,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [31:0]      redirect_pc,
  output logic             ifid_we,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_HALT
  } state_t;

  // Cycles still to flush after the redirect cycle itself.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_flush_cnt;
  logic [2:0]       w_flush_cnt_nxt;
  logic [31:0]      r_redirect;
  logic [31:0]      w_redirect_nxt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] w_taken_cnt_nxt;

  // State, flush counter, latched target and event counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
      r_redirect  <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_redirect  <= w_redirect_nxt;
      r_taken_cnt <= w_taken_cnt_nxt;
    end
  end

  // Next-state and output decode; outputs default to their reset values.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_redirect_nxt  = r_redirect;
    w_taken_cnt_nxt = r_taken_cnt;
    pc_we           = 1'b1;
    pc_sel          = 1'b0;
    redirect_pc     = '0;
    ifid_we         = 1'b1;
    flush_if_id     = 1'b0;
    flush_id_ex     = 1'b0;
    halted          = 1'b0;

    unique case (r_state)
      S_RUN: begin
        if (halt_req) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          flush_id_ex = 1'b1;
          w_state_nxt = S_HALT;
        end else if (br_taken) begin
          pc_sel         = 1'b1;
          redirect_pc    = br_target;
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          w_redirect_nxt = br_target;
          if (r_taken_cnt != '1) begin
            w_taken_cnt_nxt = r_taken_cnt + CNT_W'(1);
          end
          if (FLUSH_CYC > 1) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (stall_req) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          flush_id_ex = 1'b1;
        end
      end

      // Requests arriving here come from squashed instructions and are dropped.
      S_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        redirect_pc = r_redirect;
        if (r_flush_cnt <= 3'd1) begin
          w_state_nxt     = S_RUN;
          w_flush_cnt_nxt = '0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 3'd1;
        end
      end

      S_HALT: begin
        halted      = 1'b1;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        flush_id_ex = 1'b1;
        if (resume) begin
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_state_nxt     = S_RUN;
        w_flush_cnt_nxt = '0;
      end
    endcase
  end

  assign taken_cnt = r_taken_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (default parameters, and
// FLUSH_CYC=3/CNT_W=4) driven in lockstep and compared every cycle against a
// behavioural model, plus directed checks of the documented scenarios.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt_req;
  logic        resume;
  logic        stall_req;

  logic        a_pc_we, a_pc_sel, a_ifid_we, a_fif, a_fide, a_halted;
  logic [31:0] a_rpc;
  logic [15:0] a_cnt;
  logic        b_pc_we, b_pc_sel, b_ifid_we, b_fif, b_fide, b_halted;
  logic [31:0] b_rpc;
  logic [3:0]  b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYC(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .resume(resume), .stall_req(stall_req),
    .pc_we(a_pc_we), .pc_sel(a_pc_sel), .redirect_pc(a_rpc), .ifid_we(a_ifid_we),
    .flush_if_id(a_fif), .flush_id_ex(a_fide), .halted(a_halted), .taken_cnt(a_cnt)
  );

  branch_redirect_ctrl #(.FLUSH_CYC(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
    .halt_req(halt_req), .resume(resume), .stall_req(stall_req),
    .pc_we(b_pc_we), .pc_sel(b_pc_sel), .redirect_pc(b_rpc), .ifid_we(b_ifid_we),
    .flush_if_id(b_fif), .flush_id_ex(b_fide), .halted(b_halted), .taken_cnt(b_cnt)
  );

  logic [63:0] obs [2];
  assign obs[0] = 64'({a_pc_we, a_pc_sel, a_rpc, a_ifid_we, a_fif, a_fide, a_halted, a_cnt});
  assign obs[1] = 64'({b_pc_we, b_pc_sel, b_rpc, b_ifid_we, b_fif, b_fide, b_halted, b_cnt});

  // Behavioural model: remaining flush cycles, halted flag, event count, last target.
  int          m_flush_left [2];
  bit          m_halted     [2];
  int          m_cnt        [2];
  logic [31:0] m_tgt        [2];
  int          m_fc         [2] = '{2, 3};
  int          m_max        [2] = '{65535, 15};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flush_left[k] = 0;
      m_halted[k]     = 1'b0;
      m_cnt[k]        = 0;
      m_tgt[k]        = '0;
    end
  endfunction

  function automatic logic [63:0] model_out(int k);
    logic        pw = 1'b1, ps = 1'b0, iw = 1'b1, ff = 1'b0, fe = 1'b0, hl = 1'b0;
    logic [31:0] rp = '0;
    if (m_halted[k]) begin
      pw = 1'b0; iw = 1'b0; fe = 1'b1; hl = 1'b1;
    end else if (m_flush_left[k] > 0) begin
      ff = 1'b1; fe = 1'b1; rp = m_tgt[k];
    end else if (halt_req) begin
      pw = 1'b0; iw = 1'b0; fe = 1'b1;
    end else if (br_taken) begin
      ps = 1'b1; rp = br_target; ff = 1'b1; fe = 1'b1;
    end else if (stall_req) begin
      pw = 1'b0; iw = 1'b0; fe = 1'b1;
    end
    if (k == 0) return 64'({pw, ps, rp, iw, ff, fe, hl, 16'(m_cnt[k])});
    else        return 64'({pw, ps, rp, iw, ff, fe, hl, 4'(m_cnt[k])});
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_halted[k]) begin
        if (resume) m_halted[k] = 1'b0;
      end else if (m_flush_left[k] > 0) begin
        m_flush_left[k]--;
      end else if (halt_req) begin
        m_halted[k] = 1'b1;
      end else if (br_taken) begin
        m_cnt[k]        = (m_cnt[k] < m_max[k]) ? m_cnt[k] + 1 : m_max[k];
        m_tgt[k]        = br_target;
        m_flush_left[k] = m_fc[k] - 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_a"}, obs[0], model_out(0));
    chk({tag, "_b"}, obs[1], model_out(1));
  endtask

  // Drive inputs at the falling edge, then compare outputs against the model.
  task automatic drive(input logic bt, input logic [31:0] tg, input logic hr,
                       input logic rs, input logic sr, input string tag);
    @(negedge clk);
    br_taken = bt; br_target = tg; halt_req = hr; resume = rs; stall_req = sr;
    #1;
    check_model(tag);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input string tag);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, tag);
    tick();
  endtask

  // Asynchronous reset applied away from any clock edge.
  task automatic do_reset(input string tag);
    br_taken = 1'b0; br_target = '0; halt_req = 1'b0; resume = 1'b0; stall_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model({tag, "_async"});
    @(posedge clk);
    #1;
    check_model({tag, "_held"});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    br_taken = 1'b0; br_target = '0; halt_req = 1'b0; resume = 1'b0; stall_req = 1'b0;
    do_reset("rst0");
    chk("rst0_pc_we", 64'(a_pc_we), 64'd1);
    chk("rst0_cnt", 64'(a_cnt), 64'd0);

    // Idle after reset.
    for (int i = 0; i < 5; i++) idle("t1_idle");
    chk("t1_flush", 64'({a_fif, a_fide}), 64'd0);

    // Taken branch to 0x40.
    drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, "t2_c0");
    chk("t2_c0_sel", 64'(a_pc_sel), 64'd1);
    chk("t2_c0_rpc", 64'(a_rpc), 64'h40);
    chk("t2_c0_flush", 64'({a_fif, a_fide}), 64'd3);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t2_c1");
    chk("t2_c1_flush", 64'({a_fif, a_fide}), 64'd3);
    chk("t2_c1_sel", 64'(a_pc_sel), 64'd0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t2_c2");
    chk("t2_c2_flush_a", 64'({a_fif, a_fide}), 64'd0);
    chk("t2_c2_cnt", 64'(a_cnt), 64'd1);
    chk("t2_c2_flush_b", 64'(b_fif), 64'd1);
    tick();
    idle("t2_c3");

    // Halt wins over a same-cycle branch.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, "t3_c0");
    chk("t3_c0_pcwe", 64'({a_pc_we, a_pc_sel}), 64'd0);
    tick();
    drive(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, "t3_c1");
    chk("t3_c1_halted", 64'(a_halted), 64'd1);
    chk("t3_c1_cnt", 64'(a_cnt), 64'd1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0, "t3_c2");
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t3_c3");
    chk("t3_c3_run", 64'({a_halted, a_pc_we}), 64'd1);
    tick();

    // Two-cycle load-use stall.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, "t4_stall");
      chk("t4_stall_ctl", 64'({a_pc_we, a_ifid_we, a_fide, a_fif}), 64'b0010);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t4_after");
    chk("t4_after_ctl", 64'({a_pc_we, a_ifid_we, a_fide, a_fif}), 64'b1100);
    tick();

    // Requests during FLUSH are ignored.
    drive(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, "t5_c0");
    tick();
    drive(1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, "t5_c1");
    chk("t5_c1_rpc", 64'({a_pc_sel, a_rpc}), 64'h80);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t5_c2");
    chk("t5_c2_exit_a", 64'({a_fif, a_halted}), 64'd0);
    chk("t5_c2_cnt", 64'(a_cnt), 64'd2);
    chk("t5_c2_flush_b", 64'(b_fif), 64'd1);
    tick();
    idle("t5_c3");

    // Saturate the narrow counter, then reset mid-FLUSH.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, "t6_br");
      tick();
      for (int j = 0; j < 2; j++) idle("t6_gap");
    end
    chk("t6_sat", 64'(b_cnt), 64'hF);
    drive(1'b1, 32'hABC0, 1'b0, 1'b0, 1'b0, "t6_more");
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t6_mid");
    chk("t6_sat_hold", 64'(b_cnt), 64'hF);
    chk("t6_in_flush", 64'(b_fif), 64'd1);
    do_reset("t6_rst");
    chk("t6_rst_b", 64'({b_pc_we, b_fif, b_fide, b_rpc, b_cnt}), 64'h1_0000_0000_0 << 2);
    idle("t6_post");

    // Reset while halted.
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, "t7_halt");
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, "t7_in_halt");
    chk("t7_halted", 64'(a_halted), 64'd1);
    do_reset("t7_rst");
    chk("t7_rst_halted", 64'(a_halted), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 35), $urandom(), ($urandom_range(0, 99) < 6),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 25), "rnd");
      tick();
      if (i % 200 == 199) do_reset("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
